// File: rtl/fifo_pkg.sv
// Shared constants for the threshold FIFO and the condition FSM that drives it.
// Holds the default widths and the thresholds restored on reset.
package fifo_pkg;

    localparam int DATA_WIDTH_DEF  = 6;
    localparam int ADDR_WIDTH_DEF  = 4;
    localparam int UMBRAL_ALTO_DEF = 14;
    localparam int UMBRAL_BAJO_DEF = 2;

    // Occupancy vector needs one extra bit so a full FIFO is distinguishable from empty.
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// Storage for fifo_umbral_cond: one synchronous write port and one registered read port.
// A same-address read and write in one cycle returns the previously stored word.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array itself is not reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // NOTE: non-blocking assignment keeps the read of mem[] ordered before a same-edge write.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule : fifo_mem

// File: rtl/fifo_umbral_cond.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds and a sticky
// overflow/underflow error, both reloaded/cleared by the condition FSM's init strobe.
module fifo_umbral_cond
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
    parameter int UMBRAL_ALTO_RST = UMBRAL_ALTO_DEF,
    parameter int UMBRAL_BAJO_RST = UMBRAL_BAJO_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [ADDR_WIDTH-1:0] umbral_alto,
    input  logic [ADDR_WIDTH-1:0] umbral_bajo,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  fifo_error,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int CW    = count_width(ADDR_WIDTH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] alto_q;
    logic [ADDR_WIDTH-1:0] bajo_q;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  err_set;

    assign fifo_empty   = (count == '0);
    assign fifo_full    = (count == CW'(DEPTH));
    assign almost_full  = (count >= {1'b0, alto_q});
    assign almost_empty = (count <= {1'b0, bajo_q});

    // A full FIFO still takes a push when a pop frees a slot in the same cycle.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pop_ok  = 1'b0;
        push_ok = 1'b0;
        err_set = 1'b0;
        if (pop && !fifo_empty) begin
            pop_ok = 1'b1;
        end
        if (push && (!fifo_full || pop_ok)) begin
            push_ok = 1'b1;
        end
        if ((push && fifo_full && !pop_ok) || (pop && fifo_empty)) begin
            err_set = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // init clears the error even if a fault happens in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_error <= 1'b0;
        end else if (init) begin
            fifo_error <= 1'b0;
        end else if (err_set) begin
            fifo_error <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alto_q <= ADDR_WIDTH'(UMBRAL_ALTO_RST);
            bajo_q <= ADDR_WIDTH'(UMBRAL_BAJO_RST);
        end else if (init) begin
            alto_q <= umbral_alto;
            bajo_q <= umbral_bajo;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

endmodule : fifo_umbral_cond

// File: tb/tb_fifo_umbral_cond.sv
// Directed bench for fifo_umbral_cond: inputs change 1 ns after a rising edge and
// outputs are checked at that same point, i.e. reflecting the edge just taken.
module tb_fifo_umbral_cond;

    localparam int DW = 6;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          init = 1'b0;
    logic [AW-1:0] umbral_alto = '0;
    logic [AW-1:0] umbral_bajo = '0;
    logic          push = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          pop = 1'b0;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          fifo_empty;
    logic          fifo_full;
    logic          almost_full;
    logic          almost_empty;
    logic          fifo_error;
    logic [AW:0]   count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_umbral_cond dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .umbral_alto  (umbral_alto),
        .umbral_bajo  (umbral_bajo),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_error   (fifo_error),
        .count        (count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0;
        init  = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        idle_inputs();
        checks++;
        if (count !== 5'd0) begin
            failures++; $display("FAIL reset_count got=%0d exp=0", count);
        end
        checks++;
        if ({fifo_empty, fifo_full, almost_empty, almost_full} !== 4'b1010) begin
            failures++;
            $display("FAIL reset_flags got e/f/ae/af=%b exp=1010",
                     {fifo_empty, fifo_full, almost_empty, almost_full});
        end
        checks++;
        if ({valid_out, fifo_error, data_out} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outs got valid=%b err=%b data=%h exp 0/0/00",
                     valid_out, fifo_error, data_out);
        end
    endtask

    // Thresholds are the reset values 14/2.
    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            push    = 1'b1;
            data_in = DW'(i);
            tick();
            checks++;
            if (count !== 5'(i)) begin
                failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i);
            end
            checks++;
            if (almost_full !== (i >= 14) || almost_empty !== (i <= 2)) begin
                failures++;
                $display("FAIL fill_thresh[%0d] got af=%b ae=%b exp af=%b ae=%b",
                         i, almost_full, almost_empty, i >= 14, i <= 2);
            end
        end
        idle_inputs();
        checks++;
        if ({fifo_full, fifo_empty, fifo_error} !== 3'b100) begin
            failures++;
            $display("FAIL fill_end got full/empty/err=%b exp=100",
                     {fifo_full, fifo_empty, fifo_error});
        end
    endtask

    task automatic test_overflow();
        push    = 1'b1;
        data_in = 6'h3F;
        tick();
        idle_inputs();
        checks++;
        if (fifo_error !== 1'b1 || count !== 5'd16) begin
            failures++;
            $display("FAIL overflow got err=%b count=%0d exp err=1 count=16", fifo_error, count);
        end
        init        = 1'b1;
        umbral_alto = 4'd14;
        umbral_bajo = 4'd2;
        tick();
        idle_inputs();
        checks++;
        if (fifo_error !== 1'b0 || count !== 5'd16) begin
            failures++;
            $display("FAIL init_clear got err=%b count=%0d exp err=0 count=16", fifo_error, count);
        end
    endtask

    task automatic test_full_push_pop();
        logic [DW-1:0] exp;
        push    = 1'b1;
        pop     = 1'b1;
        data_in = 6'h11;
        tick();
        idle_inputs();
        checks++;
        if (count !== 5'd16 || data_out !== 6'h01 || valid_out !== 1'b1) begin
            failures++;
            $display("FAIL full_pushpop got count=%0d data=%h valid=%b exp 16/01/1",
                     count, data_out, valid_out);
        end
        for (int i = 0; i < 16; i++) begin
            exp = (i < 15) ? DW'(i + 2) : 6'h11;
            pop = 1'b1;
            tick();
            checks++;
            if (data_out !== exp || valid_out !== 1'b1) begin
                failures++;
                $display("FAIL drain[%0d] got data=%h valid=%b exp data=%h valid=1",
                         i, data_out, valid_out, exp);
            end
        end
        idle_inputs();
        tick();
        checks++;
        if (valid_out !== 1'b0 || data_out !== 6'h11 || fifo_empty !== 1'b1 || count !== 5'd0) begin
            failures++;
            $display("FAIL drain_end got valid=%b data=%h empty=%b count=%0d exp 0/11/1/0",
                     valid_out, data_out, fifo_empty, count);
        end
    endtask

    task automatic test_underflow_push();
        pop     = 1'b1;
        push    = 1'b1;
        data_in = 6'h2A;
        tick();
        idle_inputs();
        checks++;
        if (fifo_error !== 1'b1 || count !== 5'd1 || valid_out !== 1'b0) begin
            failures++;
            $display("FAIL underflow got err=%b count=%0d valid=%b exp 1/1/0",
                     fifo_error, count, valid_out);
        end
        pop = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (data_out !== 6'h2A || valid_out !== 1'b1 || count !== 5'd0) begin
            failures++;
            $display("FAIL underflow_pop got data=%h valid=%b count=%0d exp 2a/1/0",
                     data_out, valid_out, count);
        end
    endtask

    // init with alto=4, bajo=1 also clears the error left by the underflow test.
    task automatic test_thresholds();
        init        = 1'b1;
        umbral_alto = 4'd4;
        umbral_bajo = 4'd1;
        tick();
        idle_inputs();
        checks++;
        if (fifo_error !== 1'b0 || almost_empty !== 1'b1 || almost_full !== 1'b0) begin
            failures++;
            $display("FAIL thr_load got err=%b ae=%b af=%b exp 0/1/0",
                     fifo_error, almost_empty, almost_full);
        end
        for (int i = 1; i <= 4; i++) begin
            push    = 1'b1;
            data_in = DW'(6'h20 + i);
            tick();
            checks++;
            if (almost_empty !== (i <= 1) || almost_full !== (i >= 4)) begin
                failures++;
                $display("FAIL thr_push[%0d] got ae=%b af=%b exp ae=%b af=%b",
                         i, almost_empty, almost_full, i <= 1, i >= 4);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        for (int i = 5; i <= 9; i++) begin
            push    = 1'b1;
            data_in = DW'(i);
            tick();
        end
        idle_inputs();
        checks++;
        if (count !== 5'd9) begin
            failures++; $display("FAIL pre_reset_count got=%0d exp=9", count);
        end
        // Reset must win over a simultaneous init, push and pop.
        reset       = 1'b1;
        init        = 1'b1;
        push        = 1'b1;
        pop         = 1'b1;
        umbral_alto = 4'd3;
        umbral_bajo = 4'd7;
        tick();
        idle_inputs();
        checks++;
        if (count !== 5'd0 || fifo_empty !== 1'b1 || valid_out !== 1'b0 || data_out !== 6'h00) begin
            failures++;
            $display("FAIL mid_reset got count=%0d empty=%b valid=%b data=%h exp 0/1/0/00",
                     count, fifo_empty, valid_out, data_out);
        end
        for (int i = 1; i <= 14; i++) begin
            push    = 1'b1;
            data_in = DW'(6'h30 + i);
            tick();
            if (i == 2 || i == 3 || i == 13 || i == 14) begin
                checks++;
                if (almost_empty !== (i <= 2) || almost_full !== (i >= 14)) begin
                    failures++;
                    $display("FAIL rst_thr[%0d] got ae=%b af=%b exp ae=%b af=%b",
                             i, almost_empty, almost_full, i <= 2, i >= 14);
                end
            end
        end
        idle_inputs();
        pop = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (data_out !== 6'h31 || count !== 5'd13) begin
            failures++;
            $display("FAIL post_reset_pop got data=%h count=%0d exp 31/13", data_out, count);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_fill();
        test_overflow();
        test_full_push_pop();
        test_underflow_push();
        test_thresholds();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fifo_umbral_cond

// File: doc/fifo_umbral_cond.md
FIFO_UMBRAL_COND -- requirements
Module: fifo_umbral_cond

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 6, meaning the payload width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, meaning the address width; depth is DEPTH = 2**ADDR_WIDTH = 16.
REQ-003 SHALL have parameter UMBRAL_ALTO_RST, default 14, meaning the almost-full threshold applied after reset.
REQ-004 SHALL have parameter UMBRAL_BAJO_RST, default 2, meaning the almost-empty threshold applied after reset.
REQ-005 SHALL have port clk, input, width 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, width 1, a synchronous, active-high reset.
REQ-007 SHALL have port init, input, width 1, the threshold-load and error-clear strobe driven by the condition FSM INIT state.
REQ-008 SHALL have port umbral_alto, input, width ADDR_WIDTH, the almost-full threshold (candidate).
REQ-009 SHALL have port umbral_bajo, input, width ADDR_WIDTH, the almost-empty threshold (candidate).
REQ-010 SHALL have port push, input, width 1, the write request.
REQ-011 SHALL have port data_in, input, width DATA_WIDTH, the write data.
REQ-012 SHALL have port pop, input, width 1, the read request.
REQ-013 SHALL have port data_out, output, width DATA_WIDTH, the registered read data.
REQ-014 SHALL have port valid_out, output, width 1, which is high for one cycle when data_out holds newly popped data.
REQ-015 SHALL have port fifo_empty, output, width 1, high when count == 0; it feeds the FSM FIFO_EMPTIES input.
REQ-016 SHALL have port fifo_full, output, width 1, high when count == DEPTH.
REQ-017 SHALL have ports almost_full and almost_empty, output, width 1 each, the threshold flags.
REQ-018 SHALL have port fifo_error, output, width 1, a sticky overflow/underflow flag; it feeds the FSM FIFO_ERRORS input.
REQ-019 SHALL have port count, output, width ADDR_WIDTH+1, the current occupancy.

Function
REQ-020 SHALL latch umbral_alto and umbral_bajo into internal registers alto_q and bajo_q on any cycle with init=1, and otherwise hold them.
REQ-021 SHALL use the new alto_q/bajo_q values for the flags from the cycle after the load.
REQ-022 SHALL accept a push only if it is not full, or if it is full and pop is also accepted in the same cycle.
REQ-023 SHALL accept a pop only when count != 0; there is no same-cycle push-to-pop bypass.
REQ-024 SHALL, on an accepted push, write mem[wr_ptr] and increment wr_ptr modulo DEPTH.
REQ-025 SHALL, on an accepted pop, register mem[rd_ptr] into data_out, increment rd_ptr modulo DEPTH, and set valid_out=1 on the next cycle (1-cycle read latency).
REQ-026 SHALL update count as +1 for push only, -1 for pop only, and unchanged for both or neither.
REQ-027 SHALL set fifo_error on push while full without an accepted pop (the data is dropped and state is unchanged).
REQ-028 SHALL set fifo_error on pop while empty (it is ignored; valid_out stays 0), including when push is asserted in the same cycle (the push is still accepted).
REQ-029 SHALL keep fifo_error set until reset, or until init=1, which clears it; init has priority over a same-cycle set.
REQ-030 SHALL leave stored data, pointers and count unaffected by init.
REQ-031 SHALL compute almost_full = (count >= {0,alto_q}) and almost_empty = (count <= {0,bajo_q}), decoded combinationally from the registered count and thresholds.
REQ-032 SHALL allow alto_q < bajo_q without special handling, so both flags may be high together.
REQ-033 SHALL hold data_out at its last popped value when no pop is accepted.

Reset
REQ-034 SHALL, on reset=1 at a clock edge, set wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0 and fifo_error=0.
REQ-035 SHALL, on reset, set alto_q=UMBRAL_ALTO_RST and bajo_q=UMBRAL_BAJO_RST.
REQ-036 SHALL produce these outputs after reset: fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0.
REQ-037 SHALL give reset priority over init, push and pop, and a reset mid-operation discards all contents.

Structure
REQ-038 SHALL place the DATA_WIDTH/ADDR_WIDTH defaults and the threshold reset constants in a shared package (fifo_pkg) used with the condition FSM.
REQ-039 SHALL instantiate the storage as sub-module fifo_mem, with one synchronous write port and one registered read port; pointers, count, flags and thresholds stay in fifo_umbral_cond.

Verification
REQ-040 SHALL cover: reset, then push 0x01..0x10 on 16 consecutive cycles -> count=16, fifo_full=1, almost_full from count=14, fifo_error=0.
REQ-041 SHALL cover: with the FIFO full, push 0x3F alone -> fifo_error=1, count=16, and that data is never read out; then init=1 -> fifo_error=0 the next cycle.
REQ-042 SHALL cover: with the FIFO full, push+pop together -> count=16, data_out=0x01 with valid_out=1 one cycle later; the 16 subsequent pops return 0x02..0x10 then 0x3F-free order.
REQ-043 SHALL cover: with the FIFO empty, pop+push of 0x2A -> fifo_error=1, count=1, valid_out=0; the next pop -> data_out=0x2A.
REQ-044 SHALL cover: init=1 with umbral_alto=4 and umbral_bajo=1, then 4 pushes -> almost_empty falls at count=2 and almost_full rises at count=4.
REQ-045 SHALL cover: reset=1 asserted while count=9 -> the next cycle count=0, fifo_empty=1, and alto_q/bajo_q back to 14/2.
